// File: rtl/connect4_pkg.sv
// Shared board geometry, cell encodings and scheduler state encoding
// for the Connect Four VGA chip-draw path.
package connect4_pkg;

   localparam int COLS       = 7;
   localparam int ROWS       = 6;
   localparam int CELLS      = COLS * ROWS;
   localparam int SPRITE_PIX = 256;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_RED   = 2'b01;
   localparam logic [1:0] CELL_BLUE  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_DRAW,
      ST_FLUSH,
      ST_DONE
   } state_e;

   // Sprite origin x: origin + col*16, truncated to 8 bits.
   function automatic logic [7:0] x_of(input logic [7:0] org,
                                       input logic [2:0] col);
      return org + {1'b0, col, 4'b0000};
   endfunction

   // Sprite origin y: origin + row*16, truncated to 7 bits.
   function automatic logic [6:0] y_of(input logic [6:0] org,
                                       input logic [2:0] row);
      return org + {row, 4'b0000};
   endfunction

endpackage

// File: rtl/pix_delay_line.sv
// Aligns the plot strobe with sprite pixels that emerge from the
// drawer pipeline DEPTH cycles after the draw strobe.
module pix_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   // Shift the strobe one stage per cycle.
   always_comb begin
      sr_d    = sr_q;
      sr_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   // Stage registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/chip_draw_sched.sv
// Chip sprite draw sequencer: single-chip requests and full-board
// refresh scans, with 256-cycle draw strobes and a delayed plot.
module chip_draw_sched
   import connect4_pkg::*;
#(
   parameter int X_ORIGIN   = 24,
   parameter int Y_ORIGIN   = 12,
   parameter int PLOT_DELAY = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_col,
   input  logic [2:0] req_row,
   input  logic       req_player,
   input  logic       refresh_req,
   output logic [5:0] cell_addr,
   input  logic [1:0] cell_data,
   output logic [7:0] x_base,
   output logic [6:0] y_base,
   output logic       drawr,
   output logic       drawb,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   state_e     state_q, state_d;
   logic       pend_q, pend_d;
   logic       rf_q, rf_d;
   logic [5:0] k_q, k_d;
   logic [2:0] col_q, col_d;
   logic [2:0] row_q, row_d;
   logic       player_q, player_d;
   logic [7:0] pix_q, pix_d;
   logic [2:0] fl_q, fl_d;
   logic [5:0] cell_addr_q, cell_addr_d;
   logic [7:0] x_base_q, x_base_d;
   logic [6:0] y_base_q, y_base_d;
   logic       drawr_q, drawr_d;
   logic       drawb_q, drawb_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [5:0] k_nx;
   logic [2:0] col_nx, row_nx;
   logic       last_cell, flush_end, req_bad, cell_full;

   // Running col/row pair that tracks the scan index without a divider.
   always_comb begin
      k_nx = k_q + 6'd1;
      if (col_q == 3'(COLS - 1)) begin
         col_nx = 3'd0;
         row_nx = row_q + 3'd1;
      end else begin
         col_nx = col_q + 3'd1;
         row_nx = row_q;
      end
   end

   assign last_cell = (k_q == 6'(CELLS - 1));
   assign flush_end = (fl_q == 3'(PLOT_DELAY - 1));
   assign req_bad   = (req_col >= 3'(COLS)) || (req_row >= 3'(ROWS));
   assign cell_full = (cell_data == CELL_RED) || (cell_data == CELL_BLUE);

   assign req_ready = (state_q == ST_IDLE) && !pend_q && !refresh_req;

   // Next-state and datapath load decisions for the sequencer.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q | refresh_req;
      rf_d        = rf_q;
      k_d         = k_q;
      col_d       = col_q;
      row_d       = row_q;
      player_d    = player_q;
      pix_d       = pix_q;
      fl_d        = fl_q;
      cell_addr_d = cell_addr_q;
      x_base_d    = x_base_q;
      y_base_d    = y_base_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pend_q || refresh_req) begin
               state_d     = ST_RD_ADDR;
               pend_d      = 1'b0;
               rf_d        = 1'b1;
               k_d         = 6'd0;
               col_d       = 3'd0;
               row_d       = 3'd0;
               cell_addr_d = 6'd0;
            end else if (req_valid) begin
               rf_d     = 1'b0;
               player_d = req_player;
               if (req_bad) begin
                  state_d = ST_DONE;
               end else begin
                  state_d  = ST_DRAW;
                  pix_d    = 8'd0;
                  x_base_d = x_of(8'(X_ORIGIN), req_col);
                  y_base_d = y_of(7'(Y_ORIGIN), req_row);
               end
            end
         end
         ST_RD_ADDR: begin
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (cell_full) begin
               state_d  = ST_DRAW;
               pix_d    = 8'd0;
               player_d = (cell_data == CELL_BLUE);
               x_base_d = x_of(8'(X_ORIGIN), col_q);
               y_base_d = y_of(7'(Y_ORIGIN), row_q);
            end else if (last_cell) begin
               state_d = ST_DONE;
            end else begin
               state_d     = ST_RD_ADDR;
               k_d         = k_nx;
               col_d       = col_nx;
               row_d       = row_nx;
               cell_addr_d = k_nx;
            end
         end
         ST_DRAW: begin
            pix_d = pix_q + 8'd1;
            if (pix_q == 8'(SPRITE_PIX - 1)) begin
               state_d = ST_FLUSH;
               fl_d    = 3'd0;
            end
         end
         ST_FLUSH: begin
            if (!flush_end) begin
               fl_d = fl_q + 3'd1;
            end else if (rf_q && !last_cell) begin
               state_d     = ST_RD_ADDR;
               k_d         = k_nx;
               col_d       = col_nx;
               row_d       = row_nx;
               cell_addr_d = k_nx;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      drawr_d = (state_d == ST_DRAW) && !player_d;
      drawb_d = (state_d == ST_DRAW) && player_d;
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         pend_q      <= 1'b0;
         rf_q        <= 1'b0;
         k_q         <= 6'd0;
         col_q       <= 3'd0;
         row_q       <= 3'd0;
         player_q    <= 1'b0;
         pix_q       <= 8'd0;
         fl_q        <= 3'd0;
         cell_addr_q <= 6'd0;
         x_base_q    <= 8'd0;
         y_base_q    <= 7'd0;
         drawr_q     <= 1'b0;
         drawb_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         rf_q        <= rf_d;
         k_q         <= k_d;
         col_q       <= col_d;
         row_q       <= row_d;
         player_q    <= player_d;
         pix_q       <= pix_d;
         fl_q        <= fl_d;
         cell_addr_q <= cell_addr_d;
         x_base_q    <= x_base_d;
         y_base_q    <= y_base_d;
         drawr_q     <= drawr_d;
         drawb_q     <= drawb_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   pix_delay_line #(
      .DEPTH (PLOT_DELAY)
   ) u_plot_dly (
      .clk    (clk),
      .resetn (resetn),
      .din    (drawr_q | drawb_q),
      .dout   (plot)
   );

   assign cell_addr = cell_addr_q;
   assign x_base    = x_base_q;
   assign y_base    = y_base_q;
   assign drawr     = drawr_q;
   assign drawb     = drawb_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_chip_draw_sched.sv
// Directed bench for chip_draw_sched: single requests, refresh scans,
// arbitration, mid-draw reset and back-to-back refresh.
module tb_chip_draw_sched;
   import connect4_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_col = 3'd0;
   logic [2:0] req_row = 3'd0;
   logic       req_player = 1'b0;
   logic       refresh_req = 1'b0;
   logic [1:0] cell_data = 2'b00;
   logic       req_ready;
   logic [5:0] cell_addr;
   logic [7:0] x_base;
   logic [6:0] y_base;
   logic       drawr, drawb, plot, busy, done;

   logic [1:0] mem [64];

   int errors = 0;
   int checks = 0;

   int nr, nb, np, both, bchg, fp, lp, nd, nbu, acc;
   int dc [4];
   int bs [4];
   int bx [4];
   int by [4];
   int bc [4];
   int bl [4];

   chip_draw_sched #(
      .X_ORIGIN   (24),
      .Y_ORIGIN   (12),
      .PLOT_DELAY (2)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_col     (req_col),
      .req_row     (req_row),
      .req_player  (req_player),
      .refresh_req (refresh_req),
      .cell_addr   (cell_addr),
      .cell_data   (cell_data),
      .x_base      (x_base),
      .y_base      (y_base),
      .drawr       (drawr),
      .drawb       (drawb),
      .plot        (plot),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cell_data <= mem[cell_addr];

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic mon(input int ncyc, input int pulse_at);
      logic       drop, prevs, s;
      logic [7:0] px;
      logic [6:0] py;
      nr = 0; nb = 0; np = 0; both = 0; bchg = 0;
      fp = -1; lp = -1; nd = 0; nbu = 0; acc = -1;
      for (int j = 0; j < 4; j++) begin
         dc[j] = -1; bs[j] = -1; bx[j] = -1;
         by[j] = -1; bc[j] = -1; bl[j] = 0;
      end
      drop  = req_valid && req_ready;
      if (drop) acc = 0;
      prevs = drawr | drawb;
      px    = x_base;
      py    = y_base;
      for (int i = 1; i <= ncyc; i++) begin
         @(negedge clk);
         refresh_req = (i == pulse_at);
         if (drop) begin
            req_valid = 1'b0;
            drop      = 1'b0;
         end
         #1;
         s = drawr | drawb;
         if (s && !prevs && nbu < 4) begin
            bs[nbu] = i;
            bx[nbu] = int'(x_base);
            by[nbu] = int'(y_base);
            bc[nbu] = int'(drawb);
            nbu++;
         end
         if (s && nbu > 0) bl[nbu-1]++;
         if (s && prevs && (x_base != px || y_base != py)) bchg++;
         if (drawr) nr++;
         if (drawb) nb++;
         if (drawr && drawb) both++;
         if (plot) begin
            np++;
            if (fp < 0) fp = i;
            lp = i;
         end
         if (done) begin
            if (nd < 4) dc[nd] = i;
            nd++;
         end
         if (req_valid && req_ready && acc < 0) begin
            acc  = i;
            drop = 1'b1;
         end
         prevs = s;
         px    = x_base;
         py    = y_base;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = CELL_EMPTY;

      // reset
      repeat (3) @(negedge clk);
      #1;
      check("rst_drawr", drawr, 0);
      check("rst_drawb", drawb, 0);
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_x", x_base, 0);
      check("rst_y", y_base, 0);
      check("rst_addr", cell_addr, 0);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      check("rel_ready", req_ready, 1);
      check("rel_busy", busy, 0);

      // single red chip at col 3, row 5
      req_col = 3'd3; req_row = 3'd5; req_player = 1'b0;
      req_valid = 1'b1;
      #1;
      check("t1_ready", req_ready, 1);
      mon(260, -1);
      check("t1_nr", nr, 256);
      check("t1_nb", nb, 0);
      check("t1_start", bs[0], 1);
      check("t1_len", bl[0], 256);
      check("t1_x", bx[0], 72);
      check("t1_y", by[0], 92);
      check("t1_bchg", bchg, 0);
      check("t1_np", np, 256);
      check("t1_fp", fp, 3);
      check("t1_lp", lp, 258);
      check("t1_nd", nd, 1);
      check("t1_done", dc[0], 259);
      check("t1_ready2", req_ready, 1);

      // invalid column
      req_col = 3'd7; req_row = 3'd0; req_valid = 1'b1;
      #1;
      check("t2_ready", req_ready, 1);
      mon(2, -1);
      check("t2_strobes", nr + nb, 0);
      check("t2_np", np, 0);
      check("t2_nd", nd, 1);
      check("t2_done", dc[0], 1);
      check("t2_ready2", req_ready, 1);
      check("t2_busy", busy, 0);

      // invalid row
      req_col = 3'd0; req_row = 3'd6; req_valid = 1'b1;
      #1;
      mon(2, -1);
      check("t2r_strobes", nr + nb, 0);
      check("t2r_done", dc[0], 1);

      // refresh: cell 0 blue, cell 41 red
      mem[0]  = CELL_BLUE;
      mem[41] = CELL_RED;
      refresh_req = 1'b1;
      #1;
      check("t3_ready", req_ready, 0);
      mon(605, -1);
      check("t3_bursts", nbu, 2);
      check("t3_b0_start", bs[0], 3);
      check("t3_b0_blue", bc[0], 1);
      check("t3_b0_x", bx[0], 24);
      check("t3_b0_y", by[0], 12);
      check("t3_b0_len", bl[0], 256);
      check("t3_b1_start", bs[1], 343);
      check("t3_b1_blue", bc[1], 0);
      check("t3_b1_x", bx[1], 120);
      check("t3_b1_y", by[1], 92);
      check("t3_b1_len", bl[1], 256);
      check("t3_both", both, 0);
      check("t3_bchg", bchg, 0);
      check("t3_np", np, 512);
      check("t3_nd", nd, 1);
      check("t3_done", dc[0], 601);
      mem[0]  = CELL_EMPTY;
      mem[41] = CELL_EMPTY;

      // refresh and request in the same idle cycle
      req_col = 3'd2; req_row = 3'd1; req_player = 1'b1;
      req_valid = 1'b1;
      refresh_req = 1'b1;
      #1;
      check("t4_ready", req_ready, 0);
      mon(346, -1);
      check("t4_acc", acc, 86);
      check("t4_nd", nd, 2);
      check("t4_done0", dc[0], 85);
      check("t4_done1", dc[1], 345);
      check("t4_start", bs[0], 87);
      check("t4_blue", bc[0], 1);
      check("t4_x", bx[0], 56);
      check("t4_y", by[0], 28);
      check("t4_nb", nb, 256);
      check("t4_nr", nr, 0);

      // refresh pulsed mid-refresh on an empty board
      refresh_req = 1'b1;
      #1;
      mon(175, 20);
      check("t6_nd", nd, 2);
      check("t6_done0", dc[0], 85);
      check("t6_done1", dc[1], 171);
      check("t6_strobes", nr + nb, 0);

      // reset on the 100th draw cycle with a refresh pending
      req_col = 3'd0; req_row = 3'd0; req_player = 1'b0;
      req_valid = 1'b1;
      #1;
      mon(100, 50);
      check("t5_nr", nr, 100);
      check("t5_drawr", drawr, 1);
      resetn = 1'b0;
      @(negedge clk);
      #1;
      check("t5_drawr0", drawr, 0);
      check("t5_drawb0", drawb, 0);
      check("t5_plot0", plot, 0);
      check("t5_busy0", busy, 0);
      check("t5_done0", done, 0);
      check("t5_x0", x_base, 0);
      check("t5_y0", y_base, 0);
      resetn = 1'b1;
      mon(6, -1);
      check("t5_nd", nd, 0);
      check("t5_strobes", nr + nb, 0);
      check("t5_busy", busy, 0);
      check("t5_ready", req_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
